regfile_mp_scoreboard: RTL and testbench
========================================

Name: regfile_mp_scoreboard

Overview:
Parametrised successor to the pipeline's integer register file. It provides NREAD registered read ports, one write-back port with same-cycle write-to-read bypass, and hardwired-zero x0. A per-register busy scoreboard lets the decode stage detect RAW hazards without comparator chains. It sits between decode (read/alloc) and write-back (write/clear).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 4)
NREAD, 2, number of read ports (1..4)
SP_INIT, 32'h000001F4, reset value of register 2
GP_INIT, 32'h10000000, reset value of register 3
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset (sampled on posedge clk)
rs_addr  in  NREAD*AW  packed read addresses; port k = bits [k*AW +: AW]
rd_data  out  NREAD*XLEN  registered read data, port k = [k*XLEN +: XLEN]
rd_busy  out  NREAD  registered busy flag per read port
we  in  1  write-back enable
wr_addr  in  AW  write-back destination
wr_data  in  XLEN  write-back data
alloc_en  in  1  decode issues a producer for alloc_rd
alloc_rd  in  AW  destination being allocated
flush  in  1  clear all busy bits (pipeline flush)
busy_cnt  out  AW+1  registered count of busy registers

Behaviour:
- Reset (rst==0 at posedge):
  - regs cleared to 0, except reg2=SP_INIT and reg3=GP_INIT.
  - All busy bits 0; rd_data=0, rd_busy=0, busy_cnt=0.
  - Reset overrides we/alloc_en/flush in the same cycle, including mid-operation.
- Write: at posedge with we=1 and wr_addr!=0, regs[wr_addr] <= wr_data. Writes to 0 are ignored. Single edge only; no negedge logic.
- Read (latency 1): at posedge, for each port k:
  - rd_data[k] <= 0 if rs_addr[k]==0.
  - else wr_data if we && wr_addr==rs_addr[k] (bypass).
  - else regs[rs_addr[k]].
  - Multiple ports may read the same address; each gets an identical value.
- Scoreboard busy_next, evaluated in priority order:
  1. Start from busy.
  2. If we, clear bit wr_addr.
  3. If alloc_en and alloc_rd!=0, set bit alloc_rd. Alloc wins over a same-register clear: the new producer is pending.
  4. If flush, all bits 0 and alloc_en is ignored that cycle.
  5. Bit 0 is forced 0.
- Register updates from busy_next:
  - busy <= busy_next.
  - rd_busy[k] <= busy_next[rs_addr[k]] (0 for address 0).
  - busy_cnt <= popcount(busy_next), range 0..NREGS-1.
- A write to a non-busy register is legal: data is written and the bit stays 0.
- alloc of an already-busy register keeps the bit at 1 (no counting per register).
- No X propagation: out-of-range addresses cannot occur because AW is exact.

Test Plan:
- Reset: hold rst=0 for 2 cycles then release; read regs 2,3,5 -> rd_data = 0x1F4, 0x10000000, 0; busy_cnt=0.
- Write/read with bypass: we=1, wr_addr=5, wr_data=0xDEADBEEF, and port0 reads 5 in the same cycle -> next cycle rd_data[0]=0xDEADBEEF. Repeat the read without we -> still 0xDEADBEEF.
- x0 protection: we=1, wr_addr=0, wr_data=0xFFFFFFFF and alloc_rd=0 -> a read of 0 returns 0, rd_busy=0, busy_cnt unchanged.
- Scoreboard: alloc 7 at cycle n -> rd_busy for rs=7 is 1 at n+1 and busy_cnt=1. we to 7 at cycle m -> rd_busy=0 at m+1 and busy_cnt=0. Simultaneous we=7 and alloc=7 -> bit stays 1.
- Flush: alloc 4, 9, 12 on successive cycles (busy_cnt=3), then flush=1 with alloc_en=1, alloc_rd=6 -> busy_cnt=0, rd_busy for 6 is 0.
- Reset mid-operation: regs 8 and 10 busy, rst=0 with we=1 to reg 8 in the same cycle -> reg8 reads 0, busy_cnt=0. Also run NREAD=4 with all ports reading distinct registers -> all correct.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write-back bypass, hardwired-zero x0
// and a per-register busy scoreboard for decode-stage RAW hazard detection.
module regfile_mp_scoreboard #(
  parameter int unsigned      XLEN    = 32,
  parameter int unsigned      NREGS   = 32,
  parameter int unsigned      NREAD   = 2,
  parameter logic [XLEN-1:0]  SP_INIT = XLEN'(32'h000001F4),
  parameter logic [XLEN-1:0]  GP_INIT = XLEN'(32'h10000000),
  localparam int unsigned     AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_rd,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;
  logic [AW-1:0]    rs [NREAD];

  always_comb begin
    for (int k = 0; k < NREAD; k++) rs[k] = rs_addr[k*AW +: AW];
  end

  // Later steps override earlier ones: alloc beats a same-register clear,
  // flush beats everything, and x0 can never be pending.
  // NOTE: combinational blocks use blocking '=' with a full default first so
  // the priority chain reads top-down and no latch can be inferred.
  always_comb begin
    busy_next = busy;
    if (we) busy_next[wr_addr] = 1'b0;
    if (alloc_en && alloc_rd != '0) busy_next[alloc_rd] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) cnt_next = cnt_next + (AW+1)'(busy_next[i]);
  end

  // NOTE: the register array is reset explicitly because sp/gp carry
  // architectural reset values; this costs a reset mux per storage bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == 2) ? SP_INIT : (i == 3) ? GP_INIT : '0;
      end
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every read of busy
  // and regs in this edge sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      rd_busy  <= '0;
      rd_data  <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      for (int k = 0; k < NREAD; k++) begin
        rd_busy[k] <= busy_next[rs[k]];
        if (rs[k] == '0)
          rd_data[k*XLEN +: XLEN] <= '0;
        else if (we && wr_addr == rs[k])
          rd_data[k*XLEN +: XLEN] <= wr_data;
        else
          rd_data[k*XLEN +: XLEN] <= regs[rs[k]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed self-checking bench for regfile_mp_scoreboard with four read ports.
module tb_regfile_mp_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 4;
  localparam int AW    = 5;

  logic                  clk;
  logic                  rst;
  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  we;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  alloc_en;
  logic [AW-1:0]         alloc_rd;
  logic                  flush;
  logic [AW:0]           busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD),
    .SP_INIT(32'h000001F4), .GP_INIT(32'h10000000)
  ) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  task automatic set_rs(input logic [AW-1:0] a0, a1, a2, a3);
    rs_addr = {a3, a2, a1, a0};
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_rd = '0; flush = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    alloc_en = 1'b1; alloc_rd = a;
  endtask

  // Inputs are driven 1 time unit after a posedge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    set_rs(5'd2, 5'd3, 5'd5, 5'd7);
    tick();
    tick();
    check("reset_cnt",   32'(busy_cnt), 32'd0);
    check("reset_rd0",   rd(0), 32'd0);
    check("reset_busy",  32'(rd_busy), 32'd0);

    // Reset values of sp/gp and an ordinary register.
    rst = 1'b1;
    tick();
    check("init_r2", rd(0), 32'h000001F4);
    check("init_r3", rd(1), 32'h10000000);
    check("init_r5", rd(2), 32'h0);
    check("init_cnt", 32'(busy_cnt), 32'd0);

    // Same-cycle write-to-read bypass, then plain read.
    set_rs(5'd5, 5'd5, 5'd3, 5'd0);
    wr(5'd5, 32'hDEADBEEF);
    tick();
    check("bypass_p0", rd(0), 32'hDEADBEEF);
    check("bypass_p1", rd(1), 32'hDEADBEEF);
    check("bypass_r3", rd(2), 32'h10000000);
    idle();
    tick();
    check("reread_p0", rd(0), 32'hDEADBEEF);

    // x0 protection for write and alloc.
    set_rs(5'd0, 5'd0, 5'd0, 5'd0);
    wr(5'd0, 32'hFFFFFFFF);
    alloc(5'd0);
    tick();
    check("x0_bypass", rd(0), 32'h0);
    check("x0_busy",   32'(rd_busy), 32'd0);
    check("x0_cnt",    32'(busy_cnt), 32'd0);
    idle();
    tick();
    check("x0_read", rd(3), 32'h0);

    // Scoreboard set, clear, and alloc winning over a same-register clear.
    set_rs(5'd7, 5'd7, 5'd5, 5'd0);
    alloc(5'd7);
    tick();
    check("alloc7_busy0", 32'(rd_busy[0]), 32'd1);
    check("alloc7_busy1", 32'(rd_busy[1]), 32'd1);
    check("alloc7_busy2", 32'(rd_busy[2]), 32'd0);
    check("alloc7_cnt",   32'(busy_cnt), 32'd1);
    idle();
    wr(5'd7, 32'h00000077);
    tick();
    check("wb7_busy", 32'(rd_busy[0]), 32'd0);
    check("wb7_cnt",  32'(busy_cnt), 32'd0);
    check("wb7_data", rd(0), 32'h00000077);
    idle();
    alloc(5'd7);
    tick();
    check("realloc7_cnt", 32'(busy_cnt), 32'd1);
    wr(5'd7, 32'h00000078);
    alloc(5'd7);
    tick();
    check("wb_alloc7_busy", 32'(rd_busy[0]), 32'd1);
    check("wb_alloc7_cnt",  32'(busy_cnt), 32'd1);
    idle();
    wr(5'd7, 32'h00000079);
    tick();
    check("clear7_cnt", 32'(busy_cnt), 32'd0);

    // Successive allocs, duplicate alloc, then flush overriding an alloc.
    idle();
    set_rs(5'd4, 5'd9, 5'd12, 5'd6);
    alloc(5'd4);
    tick();
    check("alloc4_cnt", 32'(busy_cnt), 32'd1);
    alloc(5'd9);
    tick();
    check("alloc9_cnt", 32'(busy_cnt), 32'd2);
    alloc(5'd12);
    tick();
    check("alloc12_cnt",  32'(busy_cnt), 32'd3);
    check("alloc12_busy", 32'(rd_busy), 32'b0111);
    alloc(5'd4);
    tick();
    check("dup_alloc4_cnt", 32'(busy_cnt), 32'd3);
    alloc(5'd6);
    flush = 1'b1;
    tick();
    check("flush_cnt",  32'(busy_cnt), 32'd0);
    check("flush_busy", 32'(rd_busy), 32'd0);
    idle();
    tick();
    check("post_flush_cnt", 32'(busy_cnt), 32'd0);

    // Reset in the middle of activity.
    wr(5'd8, 32'h00000088);
    tick();
    idle();
    alloc(5'd8);
    tick();
    alloc(5'd10);
    tick();
    check("pre_rst_cnt", 32'(busy_cnt), 32'd2);
    idle();
    rst = 1'b0;
    wr(5'd8, 32'h00001234);
    alloc(5'd11);
    tick();
    check("midrst_cnt",  32'(busy_cnt), 32'd0);
    check("midrst_data", rd(0), 32'h0);
    idle();
    rst = 1'b1;
    set_rs(5'd8, 5'd10, 5'd2, 5'd5);
    tick();
    check("midrst_r8",   rd(0), 32'h0);
    check("midrst_r10",  rd(1), 32'h0);
    check("midrst_r2",   rd(2), 32'h000001F4);
    check("midrst_r5",   rd(3), 32'h0);
    check("midrst_busy", 32'(rd_busy), 32'd0);

    // Four ports reading distinct registers, one of them via bypass.
    wr(5'd1, 32'h11111111);  tick();
    wr(5'd13, 32'h13131313); tick();
    wr(5'd20, 32'h20202020); tick();
    wr(5'd31, 32'h31313131); tick();
    idle();
    set_rs(5'd1, 5'd13, 5'd20, 5'd31);
    tick();
    check("p4_r1",  rd(0), 32'h11111111);
    check("p4_r13", rd(1), 32'h13131313);
    check("p4_r20", rd(2), 32'h20202020);
    check("p4_r31", rd(3), 32'h31313131);
    wr(5'd20, 32'hCAFEF00D);
    tick();
    check("p4_byp_r1",  rd(0), 32'h11111111);
    check("p4_byp_r20", rd(2), 32'hCAFEF00D);
    check("p4_byp_r31", rd(3), 32'h31313131);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
